pixel_scanout: RTL and testbench

Frame-buffer owner and VGA scan-out engine for the 160x120, 3-bit-colour display. Accepts single-pixel writes from the drawing FSMs through the x/y/colour/plot interface, stores them in an on-chip frame buffer, and reads the buffer back continuously to drive the DE1-SoC VGA pins at 640x480@60 Hz, replicating each stored pixel 4x4. It is the read side of the plot interface, and the drawing FSMs connect to it in place of the adapter.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/fb_ram.sv | 27 ++
 rtl/pixel_scanout.sv | 138 +++++++++++++
 tb/tb_pixel_scanout.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared frame-buffer geometry, VGA timing and address helper
package vga_pkg;

    localparam int XSCREEN  = 160;
    localparam int YSCREEN  = 120;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int FB_DEPTH = XSCREEN * YSCREEN;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    // Per-pixel control that travels alongside the colour through the pipeline.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic vis;
    } scan_ctl_t;

    localparam scan_ctl_t SCAN_CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

    // row*160 + col without a multiplier.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
        return ({8'd0, row} << 7) + ({8'd0, row} << 5) + {7'd0, col};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port frame-buffer RAM, synchronous read, read-old-data on collision
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int DW    = COLOUR_W,
    parameter int AW    = ADDR_W
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    // No reset and no init block so the array maps onto block RAM, which powers up zero.
    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/pixel_scanout.sv
// rtl/pixel_scanout.sv - frame-buffer owner and 640x480 VGA scan-out with 4x4 pixel replication
module pixel_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam logic [9:0] LP_H_VIS   = 10'(H_VIS);
    localparam logic [9:0] LP_H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] LP_HS_FROM = 10'(H_VIS + H_FP);
    localparam logic [9:0] LP_HS_TO   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] LP_V_VIS   = 10'(V_VIS);
    localparam logic [9:0] LP_V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] LP_VS_FROM = 10'(V_VIS + V_FP);
    localparam logic [9:0] LP_VS_TO   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [7:0] LP_XS      = 8'(XSCREEN);
    localparam logic [6:0] LP_YS      = 7'(YSCREEN);

    logic                r_pix_en;
    logic [9:0]          r_hcnt;
    logic [9:0]          r_vcnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    scan_ctl_t           r_ctl;
    logic [7:0]          r_vga_r;
    logic [7:0]          r_vga_g;
    logic [7:0]          r_vga_b;
    logic                r_hs_n;
    logic                r_vs_n;
    logic                r_blank_n;

    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [COLOUR_W-1:0] w_rd_data;
    scan_ctl_t           w_ctl;

    // Writes are also gated by resetn so nothing lands in the buffer while reset is held.
    assign w_wr_en   = plot && (x < LP_XS) && (y < LP_YS) && resetn;
    assign w_wr_addr = fb_addr(y, x);

    assign w_ctl.vis  = (r_hcnt < LP_H_VIS) && (r_vcnt < LP_V_VIS);
    assign w_ctl.hs_n = !((r_hcnt >= LP_HS_FROM) && (r_hcnt <= LP_HS_TO));
    assign w_ctl.vs_n = !((r_vcnt >= LP_VS_FROM) && (r_vcnt <= LP_VS_TO));
    assign w_rd_addr  = w_ctl.vis ? fb_addr(r_vcnt[8:2], r_hcnt[9:2]) : '0;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_pix_en) begin
            if (r_hcnt == LP_H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == LP_V_LAST) ? '0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    // Stage 1: address and control; the RAM read completes on the off-phase cycle in between.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_rd_addr <= '0;
            r_ctl     <= SCAN_CTL_IDLE;
        end else if (r_pix_en) begin
            r_rd_addr <= w_rd_addr;
            r_ctl     <= w_ctl;
        end
    end

    fb_ram u_fb_ram (
        .i_clk     (CLOCK_50),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (colour),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Stage 2: pin registers, colour masked to black outside the visible region.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_vga_r   <= '0;
            r_vga_g   <= '0;
            r_vga_b   <= '0;
            r_hs_n    <= 1'b1;
            r_vs_n    <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (r_pix_en) begin
            r_vga_r   <= {8{r_ctl.vis & w_rd_data[2]}};
            r_vga_g   <= {8{r_ctl.vis & w_rd_data[1]}};
            r_vga_b   <= {8{r_ctl.vis & w_rd_data[0]}};
            r_hs_n    <= r_ctl.hs_n;
            r_vs_n    <= r_ctl.vs_n;
            r_blank_n <= r_ctl.vis;
        end
    end

    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_HS      = r_hs_n;
    assign VGA_VS      = r_vs_n;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = ~r_pix_en;

endmodule

// File: tb/tb_pixel_scanout.sv
// tb/tb_pixel_scanout.sv - scoreboard bench for pixel_scanout, full horizontal and shortened vertical timing
module tb_pixel_scanout;

    localparam int TV_VIS  = 8;
    localparam int TV_FP   = 2;
    localparam int TV_SYNC = 2;
    localparam int TV_BP   = 3;
    localparam int TV_TOT  = TV_VIS + TV_FP + TV_SYNC + TV_BP;
    localparam int TH_TOT  = 800;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    pixel_scanout #(
        .V_VIS  (TV_VIS),
        .V_FP   (TV_FP),
        .V_SYNC (TV_SYNC),
        .V_BP   (TV_BP)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         key;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       bl;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_frame = 0;
    int   cur_v = 0;
    int   mon_cnt = 0;
    logic mon_prev = 1'b1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic push(input int f, input int v, input int h, input logic [2:0] c, input logic bl);
        exp_t e;
        e.key = (f * TV_TOT + v) * TH_TOT + h;
        e.r   = c[2] ? 8'hFF : 8'h00;
        e.g   = c[1] ? 8'hFF : 8'h00;
        e.b   = c[0] ? 8'hFF : 8'h00;
        e.bl  = bl;
        sb.push_back(e);
    endtask

    // Monitor: each VGA_CLK rising edge presents one pixel; pixel p = sample index - 1.
    always @(negedge CLOCK_50) begin
        exp_t e;
        int   p;
        if (!resetn) begin
            mon_cnt  = 0;
            mon_prev = 1'b1;
        end else begin
            if (VGA_CLK && !mon_prev) begin
                if (mon_cnt > 0) begin
                    p         = mon_cnt - 1;
                    cur_v     = (p / TH_TOT) % TV_TOT;
                    cur_frame = (p / TH_TOT) / TV_TOT;
                    while (sb.size() > 0 && sb[0].key <= p) begin
                        e = sb.pop_front();
                        checks++;
                        if (e.key < p) begin
                            errors++;
                            $display("FAIL pix_missed key=%0d: got none expected sample", e.key);
                        end else if (VGA_R !== e.r || VGA_G !== e.g || VGA_B !== e.b || VGA_BLANK_N !== e.bl) begin
                            errors++;
                            $display("FAIL pix f%0d v%0d h%0d: got r=%h g=%h b=%h bl=%b expected r=%h g=%h b=%h bl=%b",
                                     cur_frame, cur_v, p % TH_TOT, VGA_R, VGA_G, VGA_B, VGA_BLANK_N,
                                     e.r, e.g, e.b, e.bl);
                        end
                    end
                end
                mon_cnt++;
            end
            mon_prev = VGA_CLK;
        end
    end

    task automatic wr(input int wx, input int wy, input logic [2:0] c);
        x      = 8'(wx);
        y      = 7'(wy);
        colour = c;
        plot   = 1'b1;
        @(posedge CLOCK_50); #1;
        plot   = 1'b0;
    endtask

    // Edge counts from the call (made just after reset release) to sync falling edges.
    task automatic measure(input int budget, output int hs_f, output int vs_f, output int vs_s);
        logic ph = VGA_HS;
        logic pv = VGA_VS;
        hs_f = -1; vs_f = -1; vs_s = -1;
        for (int n = 1; n <= budget && vs_s < 0; n++) begin
            @(posedge CLOCK_50); #1;
            if (ph && !VGA_HS && hs_f < 0) hs_f = n;
            if (pv && !VGA_VS) begin
                if (vs_f < 0) vs_f = n;
                else vs_s = n;
            end
            ph = VGA_HS;
            pv = VGA_VS;
        end
    endtask

    task automatic shape_check();
        int hs_run = 0, vs_run = 0, bl_run = 0, hs_done = 0, bl_lines = 0;
        bit vs_done = 0, vs_seen = 0;
        for (int n = 0; n < 25000 && !vs_done; n++) begin
            @(posedge CLOCK_50); #1;
            if (!VGA_HS) hs_run++;
            else if (hs_run > 0) begin
                if (hs_done < 3) chk("hs_low_len", hs_run, 192);
                hs_done++;
                hs_run = 0;
            end
            if (VGA_BLANK_N) bl_run++;
            else if (bl_run > 0) begin
                if (!vs_seen) chk("blank_len", bl_run, 1280);
                bl_lines++;
                bl_run = 0;
            end
            if (!VGA_VS) begin
                if (!vs_seen) chk("visible_lines", bl_lines, TV_VIS);
                vs_seen = 1;
                vs_run++;
            end else if (vs_run > 0) begin
                chk("vs_low_len", vs_run, 3200);
                vs_done = 1;
            end
        end
        if (!vs_done) chk("vs_shape_timeout", 0, 1);
    endtask

    initial begin
        int hs_f, vs_f, vs_s;
        int n;
        resetn = 1'b0;
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_hs", VGA_HS, 1);
        chk("rst_vs", VGA_VS, 1);
        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_sync_n", VGA_SYNC_N, 0);
        chk("rst_vga_clk", VGA_CLK, 1);

        push(0, 0, 700, 3'b000, 1'b0);
        resetn = 1'b1;
        fork
            begin
                measure(45000, hs_f, vs_f, vs_s);
                chk("hs_first_fall", hs_f, 4 + 656 * 2);
                chk("vs_first_fall", vs_f, (TV_VIS + TV_FP) * 1600 + 4);
                chk("vs_period", vs_s - vs_f, TV_TOT * 1600);
            end
            shape_check();
            begin
                wr(0, 0, 3'b100);
                wr(159, 1, 3'b011);
                wr(160, 0, 3'b111);
                wr(3, 120, 3'b111);
                wr(159, 119, 3'b011);
                push(1, 0, 0, 3'b100, 1'b1);
                push(1, 0, 3, 3'b100, 1'b1);
                push(1, 0, 4, 3'b000, 1'b1);
                push(1, 0, 12, 3'b000, 1'b1);
                push(1, 3, 0, 3'b100, 1'b1);
                push(1, 3, 3, 3'b100, 1'b1);
                push(1, 3, 4, 3'b000, 1'b1);
                push(1, 4, 0, 3'b000, 1'b1);
                push(1, 4, 3, 3'b000, 1'b1);
                push(1, 4, 636, 3'b011, 1'b1);
                push(1, 4, 639, 3'b011, 1'b1);
                push(1, 4, 640, 3'b000, 1'b0);
                push(1, 7, 636, 3'b011, 1'b1);
                push(1, 7, 639, 3'b011, 1'b1);
                push(1, 7, 640, 3'b000, 1'b0);
                push(1, 8, 0, 3'b000, 1'b0);
            end
        join

        n = 0;
        while (sb.size() > 0 && n < 30000) begin
            @(posedge CLOCK_50); n++;
        end
        chk("frame1_drained", sb.size(), 0);

        n = 0;
        while (!(cur_frame == 2 && cur_v >= 4) && n < 40000) begin
            @(posedge CLOCK_50); n++;
        end
        #1;
        chk("reach_frame2", (cur_frame == 2 && cur_v >= 4) ? 1 : 0, 1);

        resetn = 1'b0;
        x      = 8'd5;
        y      = 7'd0;
        colour = 3'b111;
        plot   = 1'b1;
        #1;
        chk("midrst_hs", VGA_HS, 1);
        chk("midrst_blank", VGA_BLANK_N, 0);
        chk("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        plot = 1'b0;
        sb.delete();
        push(0, 0, 0, 3'b100, 1'b1);
        push(0, 0, 4, 3'b000, 1'b1);
        push(0, 0, 20, 3'b000, 1'b1);
        push(0, 4, 639, 3'b011, 1'b1);
        resetn = 1'b1;
        measure(17000, hs_f, vs_f, vs_s);
        chk("post_rst_hs_fall", hs_f, 4 + 656 * 2);
        chk("post_rst_vs_fall", vs_f, (TV_VIS + TV_FP) * 1600 + 4);
        chk("post_rst_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
